// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register dump unit.
// Defaults describe the single-cycle CPU build: 25 run cycles, r0..r12 dumped.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_END_COUNT = 25;
  localparam int DEF_NUM_REGS  = 13;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/reg_dump_if.sv
// Bus between the dump unit, the register file spare read port and the dump consumer.
// Dump handshake: a word moves on a rising edge where dump_valid_o && dump_ready_i; once
// valid rises, idx/data stay stable until that edge, and ready while valid is low is ignored.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              freeze_o;
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [ADDR_W-1:0] dump_idx_o;
  logic [DATA_W-1:0] dump_data_o;
  logic              done_o;
  logic [CNT_W-1:0]  cycle_cnt_o;
  state_t            dbg_state_o;

  modport master (
    output rd_addr_o,
    output freeze_o,
    output dump_valid_o,
    output dump_idx_o,
    output dump_data_o,
    output done_o,
    output cycle_cnt_o,
    output dbg_state_o,
    input  rd_data_i,
    input  dump_ready_i
  );

  modport slave (
    input  rd_addr_o,
    input  freeze_o,
    input  dump_valid_o,
    input  dump_idx_o,
    input  dump_data_o,
    input  done_o,
    input  cycle_cnt_o,
    input  dbg_state_o,
    output rd_data_i,
    output dump_ready_i
  );

endinterface

// File: rtl/run_counter.sv
// Saturating up-counter: counts enabled edges up to LIMIT and holds there.
// tc_o flags the enabled cycle whose edge will make the count reach LIMIT.
module run_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] FULL = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != FULL)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;
  assign tc_o    = en_i && (count_q == LAST);

endmodule

// File: rtl/reg_dump_unit.sv
// Runs the CPU for END_COUNT cycles after reset, then freezes it and streams
// registers 0..NUM_REGS-1 out over a valid/ready port, one word per LOAD/SEND pair.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int END_COUNT = DEF_END_COUNT,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input logic        clk_i,
  input logic        rst_i,
  reg_dump_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] dump_idx_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              capture;
  logic              run_en;
  logic              run_tc;
  logic [CNT_W-1:0]  run_cnt;

  assign run_en = (state_q == COUNT);

  run_counter #(
    .WIDTH (CNT_W),
    .LIMIT (END_COUNT)
  ) u_run_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (run_en),
    .count_o (run_cnt),
    .tc_o    (run_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= COUNT;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        dump_data_q <= bus.rd_data_i;
        dump_idx_q  <= idx_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      COUNT: begin
        if (run_tc) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        capture = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.dump_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = COUNT;
      end
    endcase
  end

  // rd_addr_o follows the index register so the read port is settled for the whole LOAD cycle.
  assign bus.rd_addr_o    = idx_q;
  assign bus.freeze_o     = (state_q != COUNT);
  assign bus.dump_valid_o = (state_q == SEND);
  assign bus.done_o       = (state_q == DONE);
  assign bus.dump_idx_o   = dump_idx_q;
  assign bus.dump_data_o  = dump_data_q;
  assign bus.cycle_cnt_o  = run_cnt;
  assign bus.dbg_state_o  = state_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: ready-high dump, backpressure, reset mid-dump,
// ready pulses while idle, and an END_COUNT=1 / NUM_REGS=1 instance.
module tb_reg_dump_unit;
  import reg_dump_pkg::*;

  logic        clk;
  logic        rst;
  logic        rst_b;
  logic        ready;
  logic        ready_b;
  logic [31:0] rf_bias;
  int          checks;
  int          errors;
  logic [31:0] exp_q[$];

  reg_dump_if #(.ADDR_W(5), .DATA_W(32)) dif ();
  reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bif ();

  // Register file stub: rN reads as A000_0000 + N, plus a bias used to disturb a stall.
  assign dif.rd_data_i    = 32'hA000_0000 + 32'(dif.rd_addr_o) + rf_bias;
  assign dif.dump_ready_i = ready;
  assign bif.rd_data_i    = 32'hA000_0000 + 32'(bif.rd_addr_o);
  assign bif.dump_ready_i = ready_b;

  reg_dump_unit #(
    .END_COUNT (25),
    .NUM_REGS  (13),
    .DATA_W    (32),
    .ADDR_W    (5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dif)
  );

  reg_dump_unit #(
    .END_COUNT (1),
    .NUM_REGS  (1),
    .DATA_W    (32),
    .ADDR_W    (5)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bif)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each tick advances exactly one rising edge; sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dif.dbg_state_o), 32'(COUNT));
    check({tag, "_cnt"},   32'(dif.cycle_cnt_o), 32'd0);
    check({tag, "_addr"},  32'(dif.rd_addr_o), 32'd0);
    check({tag, "_idx"},   32'(dif.dump_idx_o), 32'd0);
    check({tag, "_data"},  dif.dump_data_o, 32'd0);
    check({tag, "_freeze"}, 32'(dif.freeze_o), 32'd0);
    check({tag, "_valid"}, 32'(dif.dump_valid_o), 32'd0);
    check({tag, "_done"},  32'(dif.done_o), 32'd0);
  endtask

  // Ready held high from reset release: word k appears after edge 26+2k, done after edge 51.
  task automatic run_tied_high(input string tag);
    logic [31:0] exp_d;
    int          hs;
    hs = 0;
    exp_q.delete();
    for (int k = 0; k < 13; k++) exp_q.push_back(32'hA000_0000 + 32'(k));
    ready = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      tick();
      check($sformatf("%s_cnt_e%0d", tag, e), 32'(dif.cycle_cnt_o), (e < 25) ? 32'(e) : 32'd25);
      check($sformatf("%s_freeze_e%0d", tag, e), 32'(dif.freeze_o), (e >= 25) ? 32'd1 : 32'd0);
      check($sformatf("%s_valid_e%0d", tag, e), 32'(dif.dump_valid_o),
            (e >= 26 && e <= 50 && (e % 2 == 0)) ? 32'd1 : 32'd0);
      check($sformatf("%s_done_e%0d", tag, e), 32'(dif.done_o), (e >= 51) ? 32'd1 : 32'd0);
      if (dif.dump_valid_o) begin
        hs++;
        check($sformatf("%s_idx_e%0d", tag, e), 32'(dif.dump_idx_o), 32'((e - 26) / 2));
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("%s_data_e%0d", tag, e), dif.dump_data_o, exp_d);
      end
    end
    check({tag, "_handshakes"}, 32'(hs), 32'd13);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    ready = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int waited;
    waited = 0;
    while (!dif.dump_valid_o && waited < 4) begin
      tick();
      waited++;
    end
    check($sformatf("bp_valid_k%0d", k), 32'(dif.dump_valid_o), 32'd1);
    check($sformatf("bp_idx_k%0d", k), 32'(dif.dump_idx_o), 32'(k));
    check($sformatf("bp_data_k%0d", k), dif.dump_data_o, 32'hA000_0000 + 32'(k));
  endtask

  // One word with ready held low for `stall` cycles; the register file changes mid-stall.
  task automatic recv_word(input int k, input int stall);
    wait_valid(k);
    for (int s = 0; s < stall; s++) begin
      if (s == 1) rf_bias = 32'h0000_0100;
      tick();
      check($sformatf("stall_valid_k%0d_s%0d", k, s), 32'(dif.dump_valid_o), 32'd1);
      check($sformatf("stall_idx_k%0d_s%0d", k, s), 32'(dif.dump_idx_o), 32'(k));
      check($sformatf("stall_data_k%0d_s%0d", k, s), dif.dump_data_o, 32'hA000_0000 + 32'(k));
    end
    rf_bias = 32'd0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check($sformatf("bp_after_hs_valid_k%0d", k), 32'(dif.dump_valid_o), 32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    rst_b   = 1'b1;
    ready   = 1'b0;
    ready_b = 1'b0;
    rf_bias = 32'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    check("b_reset_state", 32'(bif.dbg_state_o), 32'(COUNT));
    check("b_reset_freeze", 32'(bif.freeze_o), 32'd0);

    // Ready tied high, full dump
    rst = 1'b0;
    run_tied_high("run1");

    // Reset out of DONE, then ready pulsed on odd edges while nothing is valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset_from_done");
    for (int e = 1; e <= 25; e++) begin
      ready = (e % 2 == 1);
      tick();
      check($sformatf("idle_cnt_e%0d", e), 32'(dif.cycle_cnt_o), 32'(e));
      check($sformatf("idle_state_e%0d", e), 32'(dif.dbg_state_o),
            (e < 25) ? 32'(COUNT) : 32'(LOAD));
      check($sformatf("idle_valid_e%0d", e), 32'(dif.dump_valid_o), 32'd0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("load_ignores_ready_state", 32'(dif.dbg_state_o), 32'(SEND));
    check("load_ignores_ready_idx", 32'(dif.dump_idx_o), 32'd0);
    check("cnt_saturated", 32'(dif.cycle_cnt_o), 32'd25);

    // Backpressure on idx 4, then reset while idx 6 is being offered
    for (int k = 0; k < 6; k++) recv_word(k, (k == 4) ? 7 : 0);
    wait_valid(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset_mid_send");
    run_tied_high("replay");

    // Minimum parameters: LOAD at edge 1, one word, done after edge 3
    rst_b = 1'b0;
    tick();
    check("b_e1_state", 32'(bif.dbg_state_o), 32'(LOAD));
    check("b_e1_cnt", 32'(bif.cycle_cnt_o), 32'd1);
    check("b_e1_freeze", 32'(bif.freeze_o), 32'd1);
    check("b_e1_valid", 32'(bif.dump_valid_o), 32'd0);
    ready_b = 1'b1;
    tick();
    check("b_e2_valid", 32'(bif.dump_valid_o), 32'd1);
    check("b_e2_idx", 32'(bif.dump_idx_o), 32'd0);
    check("b_e2_data", bif.dump_data_o, 32'hA000_0000);
    check("b_e2_done", 32'(bif.done_o), 32'd0);
    tick();
    check("b_e3_done", 32'(bif.done_o), 32'd1);
    check("b_e3_valid", 32'(bif.dump_valid_o), 32'd0);
    check("b_e3_state", 32'(bif.dbg_state_o), 32'(DONE));
    tick();
    tick();
    check("b_hold_done", 32'(bif.done_o), 32'd1);
    check("b_hold_cnt", 32'(bif.cycle_cnt_o), 32'd1);
    check("b_hold_freeze", 32'(bif.freeze_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
